// File: rtl/lsu_dcache_req_arbiter_if.sv
// ============================================================================
// Module : lsu_dcache_req_arbiter_pkg / lsu_dcache_req_arbiter_if
// Brief  : Request/branch types and the requester <-> D$ handshake bundle
//          used by the LSU D$ request arbiter.
//          Bundle signals:
//            ptw_req/ptw_gnt  page-table walker request and grant
//            ld_req/ld_gnt    load pipeline request and grant
//            st_req/st_gnt    committed-store drain request and grant
//            dc_req/dc_ready  request presented to the D$ and its accept
//          master = requesters + D$ side, slave = arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_dcache_req_arbiter_pkg;

  typedef struct packed {
    logic [11:0] br_mask;   // branches this uop is speculative under
    logic        load;
    logic        store;
  } uop_t;

  typedef struct packed {
    logic        dreq_valid;
    logic [39:0] addr;
    logic [63:0] data;
    uop_t        uop;
    logic        is_hella;  // walker request
  } dc_req_t;

  typedef struct packed {
    logic        mispredict;
    logic [11:0] mispredict_mask;
    logic [11:0] resolve_mask;
  } brupdate_t;

endpackage

interface lsu_dcache_req_arbiter_if;
  import lsu_dcache_req_arbiter_pkg::*;

  dc_req_t ptw_req;
  logic    ptw_gnt;
  dc_req_t ld_req;
  logic    ld_gnt;
  dc_req_t st_req;
  logic    st_gnt;
  dc_req_t dc_req;
  logic    dc_ready;

  modport master (
    output ptw_req, ld_req, st_req, dc_ready,
    input  ptw_gnt, ld_gnt, st_gnt, dc_req
  );

  modport slave (
    input  ptw_req, ld_req, st_req, dc_ready,
    output ptw_gnt, ld_gnt, st_gnt, dc_req
  );
endinterface

`default_nettype wire

// File: rtl/lsu_dcache_req_arbiter.sv
// ============================================================================
// Module : lsu_dcache_req_arbiter
// Brief  : Shares the single D$ request port between the page-table walker,
//          the load pipeline and the committed-store drain. One registered
//          output buffer holds the winning request until the D$ accepts it.
//          Speculative loads are killed on mispredict/flush; a starvation
//          counter guarantees store forward progress.
// Ports  : clk        rising-edge clock
//          rst        asynchronous active-high reset
//          bus        requester/D$ handshake bundle (slave side)
//          stq_full   STQ full, store outranks loads
//          brupdate   branch resolve/mispredict broadcast
//          flush      pipeline flush, kills loads
//          starve_cnt store starvation count (debug)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lsu_dcache_req_arbiter
  import lsu_dcache_req_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = 8,
  parameter int CNT_W      = 4
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  lsu_dcache_req_arbiter_if.slave        bus,
  input  wire logic                      stq_full,
  input  wire brupdate_t                 brupdate,
  input  wire logic                      flush,
  output logic [CNT_W-1:0]               starve_cnt
);

  localparam logic [CNT_W-1:0] c_starve_lim = CNT_W'(STARVE_LIM);

  logic             r_buf_v;
  dc_req_t          r_buf;
  logic [CNT_W-1:0] r_starve;

  logic    w_kill_buf;
  logic    w_kill_ld;
  logic    w_dc_fire;
  logic    w_can_acc;
  logic    w_ptw_v;
  logic    w_ld_v;
  logic    w_st_v;
  logic    w_st_force;
  logic    w_any_gnt;
  dc_req_t w_sel;
  dc_req_t w_nxt;

  // Only loads are speculative; walker and store requests are never killed.
  function automatic logic load_killed(input uop_t u, input logic fl,
                                       input brupdate_t bu);
    return u.load & (fl | (bu.mispredict & |(u.br_mask & bu.mispredict_mask)));
  endfunction

  assign w_kill_buf = r_buf_v & load_killed(r_buf.uop, flush, brupdate);
  assign w_kill_ld  = load_killed(bus.ld_req.uop, flush, brupdate);

  always_comb begin
    bus.dc_req            = r_buf;
    bus.dc_req.dreq_valid = r_buf_v & ~w_kill_buf;
  end

  assign w_dc_fire = bus.dc_req.dreq_valid & bus.dc_ready;
  // A killed buffer entry frees the slot in the same cycle it is dropped.
  assign w_can_acc = ~r_buf_v | w_dc_fire | w_kill_buf;

  assign w_ptw_v    = bus.ptw_req.dreq_valid;
  assign w_ld_v     = bus.ld_req.dreq_valid & ~w_kill_ld;
  assign w_st_v     = bus.st_req.dreq_valid;
  assign w_st_force = w_st_v & (stq_full | (r_starve == c_starve_lim));

  always_comb begin
    bus.ptw_gnt = 1'b0;
    bus.ld_gnt  = 1'b0;
    bus.st_gnt  = 1'b0;
    w_sel       = bus.st_req;
    if (w_can_acc) begin
      if (w_ptw_v) begin
        bus.ptw_gnt = 1'b1;
        w_sel       = bus.ptw_req;
      end else if (w_st_force) begin
        bus.st_gnt  = 1'b1;
        w_sel       = bus.st_req;
      end else if (w_ld_v) begin
        bus.ld_gnt  = 1'b1;
        w_sel       = bus.ld_req;
      end else if (w_st_v) begin
        bus.st_gnt  = 1'b1;
        w_sel       = bus.st_req;
      end
    end
  end

  assign w_any_gnt = bus.ptw_gnt | bus.ld_gnt | bus.st_gnt;

  // Captured request already sees this cycle's branch resolution.
  always_comb begin
    w_nxt             = w_sel;
    w_nxt.dreq_valid  = 1'b1;
    w_nxt.uop.br_mask = w_sel.uop.br_mask & ~brupdate.resolve_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_v <= 1'b0;
      r_buf   <= '0;
    end else if (w_any_gnt) begin
      r_buf_v <= 1'b1;
      r_buf   <= w_nxt;
    end else begin
      if (w_dc_fire | w_kill_buf) begin
        r_buf_v <= 1'b0;
      end
      // Only the branch mask may change while a request is held.
      r_buf.uop.br_mask <= r_buf.uop.br_mask & ~brupdate.resolve_mask;
    end
  end

  // Loss to the walker does not count; only losses to loads do.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!w_st_v || bus.st_gnt) begin
      r_starve <= '0;
    end else if (bus.ld_gnt && (r_starve != c_starve_lim)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign starve_cnt = r_starve;

endmodule

`default_nettype wire
